// File: rtl/memory_arb_pkg.sv
// Shared types and constants for the two-port SPRAM initiator arbiter.
package memory_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  // Cycles from issuing a read to the memory presenting its data
  localparam int RD_LATENCY = 1;

  function automatic port_sel_t other_port(input port_sel_t sel);
    return (sel == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/mem_rd_return.sv
// Per-port read return path: tracks an outstanding read and captures the
// memory's data into a hold register when it arrives.
module mem_rd_return
  import memory_arb_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_rd_i,
  input  logic [BITS-1:0] mem_rdata_i,
  output logic            rvalid_o,
  output logic [BITS-1:0] rdata_o
);

  logic [RD_LATENCY-1:0] pend_q, pend_d;
  logic [BITS-1:0]       rdata_q, rdata_d;

  // A read pending across reset must never surface as a valid strobe
  always_comb begin
    pend_d   = (pend_q << 1) | RD_LATENCY'(issue_rd_i);
    rvalid_o = pend_q[RD_LATENCY-1] & ~rst_i;
    rdata_d  = rvalid_o ? mem_rdata_i : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single-port SPRAM with lock support.
// Define MEMORY_ARB_FIXED_PRIO_EN to give port A fixed priority instead of round-robin.
module memory_arbiter
  import memory_arb_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    A_REQ,
  input  logic [ADDRESS_BITS-1:0] A_ADDR,
  input  logic [BITS-1:0]         A_WDATA,
  input  logic                    A_WR,
  input  logic                    A_LOCK,
  output logic                    A_ACK,
  output logic                    A_RVALID,
  output logic [BITS-1:0]         A_RDATA,
  input  logic                    B_REQ,
  input  logic [ADDRESS_BITS-1:0] B_ADDR,
  input  logic [BITS-1:0]         B_WDATA,
  input  logic                    B_WR,
  input  logic                    B_LOCK,
  output logic                    B_ACK,
  output logic                    B_RVALID,
  output logic [BITS-1:0]         B_RDATA,
  output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
  output logic [BITS-1:0]         MEM_WDATA,
  input  logic [BITS-1:0]         MEM_RDATA,
  output logic                    MEM_WR
);

  owner_t                  owner_q, owner_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0]         wdata_q, wdata_d;
  logic                    grant_valid;
  port_sel_t               grant_sel;
  logic                    sel_lock;
`ifndef MEMORY_ARB_FIXED_PRIO_EN
  port_sel_t               rr_q, rr_d;
`endif

  // Grant: a requesting owner first, then a lone requester, then the tie-break
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = PORT_A;
    if (!RST) begin
      if (owner_q == OWN_A && A_REQ) begin
        grant_valid = 1'b1;
        grant_sel   = PORT_A;
      end else if (owner_q == OWN_B && B_REQ) begin
        grant_valid = 1'b1;
        grant_sel   = PORT_B;
      end else if (A_REQ && !B_REQ) begin
        grant_valid = 1'b1;
        grant_sel   = PORT_A;
      end else if (B_REQ && !A_REQ) begin
        grant_valid = 1'b1;
        grant_sel   = PORT_B;
      end else if (A_REQ && B_REQ) begin
        grant_valid = 1'b1;
`ifdef MEMORY_ARB_FIXED_PRIO_EN
        grant_sel   = PORT_A;
`else
        grant_sel   = rr_q;
`endif
      end
    end
  end

  // Idle cycles replay the last address/data with WR low so the memory sees no write
  always_comb begin
    A_ACK       = grant_valid && (grant_sel == PORT_A);
    B_ACK       = grant_valid && (grant_sel == PORT_B);
    MEM_ADDRESS = addr_q;
    MEM_WDATA   = wdata_q;
    MEM_WR      = 1'b0;
    sel_lock    = 1'b0;
    if (A_ACK) begin
      MEM_ADDRESS = A_ADDR;
      MEM_WDATA   = A_WDATA;
      MEM_WR      = A_WR;
      sel_lock    = A_LOCK;
    end else if (B_ACK) begin
      MEM_ADDRESS = B_ADDR;
      MEM_WDATA   = B_WDATA;
      MEM_WR      = B_WR;
      sel_lock    = B_LOCK;
    end
    addr_d  = MEM_ADDRESS;
    wdata_d = MEM_WDATA;
  end

  always_comb begin
    owner_d = owner_q;
    if (grant_valid) begin
      if (sel_lock) begin
        owner_d = (grant_sel == PORT_A) ? OWN_A : OWN_B;
      end else begin
        owner_d = OWN_NONE;
      end
    end else if ((owner_q == OWN_A && !A_REQ) || (owner_q == OWN_B && !B_REQ)) begin
      owner_d = OWN_NONE;
    end
  end

`ifndef MEMORY_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      rr_d = other_port(grant_sel);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q <= PORT_A;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  mem_rd_return #(
    .BITS(BITS)
  ) u_rd_return_a (
    .clk_i      (CLK),
    .rst_i      (RST),
    .issue_rd_i (A_ACK && !A_WR),
    .mem_rdata_i(MEM_RDATA),
    .rvalid_o   (A_RVALID),
    .rdata_o    (A_RDATA)
  );

  mem_rd_return #(
    .BITS(BITS)
  ) u_rd_return_b (
    .clk_i      (CLK),
    .rst_i      (RST),
    .issue_rd_i (B_ACK && !B_WR),
    .mem_rdata_i(MEM_RDATA),
    .rvalid_o   (B_RVALID),
    .rdata_o    (B_RDATA)
  );

endmodule
